ghost_loc_ctrl: RTL and testbench

- Greedy chase controller for two ghosts on the 40x30 maze grid.
- Once per movement period, scores the four neighbours (up, down, left, right) of each ghost against pacman's position and registers the cheapest one as that ghost's next cell.
- The renderer commits the move by pulsing wrdone.
- Contains the proximity scorer (the ghost map function) and the period counter.

---
 rtl/ghost_loc_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_ghost_loc_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ghost_loc_ctrl.sv
// rtl/ghost_loc_ctrl.sv - greedy two-ghost chase controller with proximity scorer and period counter
// Purpose: once per DELAY-clock period, scores the four neighbours of each ghost
// against pacman and registers the cheapest one as that ghost's next cell.
// Ports:
//   CLOCK_50                      system clock, rising edge
//   reset                         asynchronous active-low reset
//   enable                        allows a new evaluation to start from INIT
//   wrdone                        one-cycle commit pulse: curr <= next, prev <= curr
//   curr_pacman_x / curr_pacman_y pacman column (6b) / row (5b)
//   curr_ghostN_x / curr_ghostN_y committed ghost positions
//   next_ghostN_x / next_ghostN_y chosen next positions
module ghost_loc_ctrl #(
  parameter int DELAY = 30000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  input  logic       wrdone,
  input  logic [5:0] curr_pacman_x,
  input  logic [4:0] curr_pacman_y,
  output logic [5:0] curr_ghost1_x,
  output logic [4:0] curr_ghost1_y,
  output logic [5:0] curr_ghost2_x,
  output logic [4:0] curr_ghost2_y,
  output logic [5:0] next_ghost1_x,
  output logic [4:0] next_ghost1_y,
  output logic [5:0] next_ghost2_x,
  output logic [4:0] next_ghost2_y
);

  localparam int CW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DELAY - 1);
  localparam logic [10:0] G1_HOME = {6'd16, 5'd13};
  localparam logic [10:0] G2_HOME = {6'd23, 5'd13};

  // Scan states are numbered so that (state-1) encodes {ghost, dir[1:0], compare}.
  typedef enum logic [4:0] {
    INIT, C1U_H, C1U, C1D_H, C1D, C1L_H, C1L, C1R_H, C1R,
    C2U_H, C2U, C2D_H, C2D, C2L_H, C2L, C2R_H, C2R, DONE
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] counter_q, counter_d;
  // Positions are packed as {x[5:0], y[4:0]}.
  logic [10:0] curr1_q, curr1_d, curr2_q, curr2_d;
  logic [10:0] next1_q, next1_d, next2_q, next2_d;
  logic [10:0] prev1_q, prev1_d, prev2_q, prev2_d;
  logic [10:0] pos1_q, pos1_d, pos2_q, pos2_d;
  logic [10:0] min1_q, min1_d, min2_q, min2_d;
  logic [7:0]  minv1_q, minv1_d, minv2_q, minv2_d;
  logic [7:0]  cost_q, cost_d;

  logic [3:0]  scan_idx;
  logic        sel_g2;
  logic [1:0]  dir;
  logic        is_cmp;
  logic [10:0] base, prev_sel, cand;
  logic [5:0]  cx, dx;
  logic [4:0]  cy, dy;

  // Ghost map function: candidate cell for the current scan state and its cost.
  // The cost is registered, so a hold state presents the cell and the following
  // compare state sees the matching cost in cost_q.
  always_comb begin
    scan_idx = 4'(state_q - 5'd1);
    sel_g2   = scan_idx[3];
    dir      = scan_idx[2:1];
    is_cmp   = scan_idx[0];
    base     = sel_g2 ? pos2_q : pos1_q;
    prev_sel = sel_g2 ? prev2_q : prev1_q;
    cx       = base[10:5];
    cy       = base[4:0];
    case (dir)
      2'd0:    cy = base[4:0] - 5'd1;
      2'd1:    cy = base[4:0] + 5'd1;
      2'd2:    cx = base[10:5] - 6'd1;
      default: cx = base[10:5] + 6'd1;
    endcase
    cand = {cx, cy};
    dx   = (cx > curr_pacman_x) ? (cx - curr_pacman_x) : (curr_pacman_x - cx);
    dy   = (cy > curr_pacman_y) ? (cy - curr_pacman_y) : (curr_pacman_y - cy);
    // Off-grid cells (including wrapped 0-1) and the reversal cell are blocked.
    if (cx > 6'd39 || cy > 5'd29 || cand == prev_sel) begin
      cost_d = 8'd255;
    end else begin
      cost_d = {2'b00, dx} + {3'b000, dy};
    end
  end

  always_comb begin
    state_d = state_q;
    curr1_d = curr1_q;
    curr2_d = curr2_q;
    next1_d = next1_q;
    next2_d = next2_q;
    prev1_d = prev1_q;
    prev2_d = prev2_q;
    pos1_d  = pos1_q;
    pos2_d  = pos2_q;
    min1_d  = min1_q;
    min2_d  = min2_q;
    minv1_d = minv1_q;
    minv2_d = minv2_q;

    case (state_q)
      INIT: begin
        pos1_d  = curr1_q;
        pos2_d  = curr2_q;
        // Seed of 254 lets any legal cell win while all-blocked keeps the ghost put.
        min1_d  = curr1_q;
        min2_d  = curr2_q;
        minv1_d = 8'd254;
        minv2_d = 8'd254;
        if (enable) state_d = C1U_H;
      end
      DONE: begin
        next1_d = min1_q;
        next2_d = min2_q;
        if (counter_q == '0) state_d = INIT;
      end
      default: begin
        state_d = state_t'(state_q + 5'd1);
        // Strict less-than: ties keep the earlier candidate in up/down/left/right order.
        if (is_cmp && !sel_g2 && cost_q < minv1_q) begin
          min1_d  = cand;
          minv1_d = cost_q;
        end
        if (is_cmp && sel_g2 && cost_q < minv2_q) begin
          min2_d  = cand;
          minv2_d = cost_q;
        end
      end
    endcase

    // Cleared on entering and leaving INIT so the first scan state sees zero.
    if (state_q == INIT || state_d == INIT) begin
      counter_d = '0;
    end else if (counter_q == CNT_MAX) begin
      counter_d = '0;
    end else begin
      counter_d = counter_q + CW'(1);
    end

    // Commit uses the registered next, so a coincident DONE update lands a period later.
    if (wrdone) begin
      curr1_d = next1_q;
      curr2_d = next2_q;
      prev1_d = curr1_q;
      prev2_d = curr2_q;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q   <= INIT;
      counter_q <= '0;
      curr1_q   <= G1_HOME;
      curr2_q   <= G2_HOME;
      next1_q   <= G1_HOME;
      next2_q   <= G2_HOME;
      prev1_q   <= G1_HOME;
      prev2_q   <= G2_HOME;
      pos1_q    <= G1_HOME;
      pos2_q    <= G2_HOME;
      min1_q    <= G1_HOME;
      min2_q    <= G2_HOME;
      minv1_q   <= 8'd254;
      minv2_q   <= 8'd254;
      cost_q    <= 8'd255;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      curr1_q   <= curr1_d;
      curr2_q   <= curr2_d;
      next1_q   <= next1_d;
      next2_q   <= next2_d;
      prev1_q   <= prev1_d;
      prev2_q   <= prev2_d;
      pos1_q    <= pos1_d;
      pos2_q    <= pos2_d;
      min1_q    <= min1_d;
      min2_q    <= min2_d;
      minv1_q   <= minv1_d;
      minv2_q   <= minv2_d;
      cost_q    <= cost_d;
    end
  end

  assign curr_ghost1_x = curr1_q[10:5];
  assign curr_ghost1_y = curr1_q[4:0];
  assign curr_ghost2_x = curr2_q[10:5];
  assign curr_ghost2_y = curr2_q[4:0];
  assign next_ghost1_x = next1_q[10:5];
  assign next_ghost1_y = next1_q[4:0];
  assign next_ghost2_x = next2_q[10:5];
  assign next_ghost2_y = next2_q[4:0];

endmodule

// File: tb/tb_ghost_loc_ctrl.sv
// tb/tb_ghost_loc_ctrl.sv - directed self-checking bench for ghost_loc_ctrl
module tb_ghost_loc_ctrl;
  localparam int DELAY = 2400;

  logic       clk = 1'b0;
  logic       reset, enable, wrdone;
  logic [5:0] px;
  logic [4:0] py;
  logic [5:0] c1x, c2x, n1x, n2x;
  logic [4:0] c1y, c2y, n1y, n2y;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int px, py, n1x, n1y, n2x, n2y;
  } vec_t;

  vec_t vecs [8];

  always #5 clk = ~clk;

  ghost_loc_ctrl #(.DELAY(DELAY)) dut (
    .CLOCK_50      (clk),
    .reset         (reset),
    .enable        (enable),
    .wrdone        (wrdone),
    .curr_pacman_x (px),
    .curr_pacman_y (py),
    .curr_ghost1_x (c1x),
    .curr_ghost1_y (c1y),
    .curr_ghost2_x (c2x),
    .curr_ghost2_y (c2y),
    .next_ghost1_x (n1x),
    .next_ghost1_y (n1y),
    .next_ghost2_x (n2x),
    .next_ghost2_y (n2y)
  );

  task automatic check_pos(input string name, input logic [5:0] ax, input logic [4:0] ay,
                           input int ex, input int ey);
    n_tests++;
    if ({ax, ay} !== {6'(ex), 5'(ey)}) begin
      n_fail++;
      $display("FAIL %s: got (%0d,%0d) expected (%0d,%0d)", name, ax, ay, ex, ey);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves reset released at a falling edge; the next rising edge leaves INIT.
  task automatic do_reset(input int x, input int y);
    reset  = 1'b0;
    enable = 1'b1;
    wrdone = 1'b0;
    px     = 6'(x);
    py     = 5'(y);
    cyc(3);
    reset  = 1'b1;
  endtask

  // Commit pulse followed by the rest of one full period.
  task automatic pulse_wr();
    wrdone = 1'b1;
    cyc(1);
    wrdone = 1'b0;
    cyc(DELAY + 1);
  endtask

  initial begin
    int ex, ey, nx, ny;

    reset  = 1'b0;
    enable = 1'b1;
    wrdone = 1'b0;
    px     = 6'd20;
    py     = 5'd20;

    vecs[0] = '{20, 20, 16, 14, 23, 14};
    vecs[1] = '{17, 13, 17, 13, 22, 13};
    vecs[2] = '{16, 13, 16, 12, 22, 13};
    vecs[3] = '{39, 29, 16, 14, 23, 14};
    vecs[4] = '{ 0,  0, 16, 12, 23, 12};
    vecs[5] = '{16,  2, 16, 12, 23, 12};
    vecs[6] = '{30, 13, 17, 13, 24, 13};
    vecs[7] = '{63, 31, 16, 14, 23, 14};

    // Reset held: outputs pinned to home positions even with wrdone toggling.
    for (int i = 0; i < 5; i++) begin
      wrdone = i[0];
      cyc(1);
      check_pos($sformatf("reset_hold[%0d] curr1", i), c1x, c1y, 16, 13);
      check_pos($sformatf("reset_hold[%0d] next1", i), n1x, n1y, 16, 13);
      check_pos($sformatf("reset_hold[%0d] curr2", i), c2x, c2y, 23, 13);
      check_pos($sformatf("reset_hold[%0d] next2", i), n2x, n2y, 23, 13);
    end
    wrdone = 1'b0;

    // First evaluation from home for a table of pacman positions.
    for (int v = 0; v < 8; v++) begin
      do_reset(vecs[v].px, vecs[v].py);
      cyc(30);
      check_pos($sformatf("vec%0d next1", v), n1x, n1y, vecs[v].n1x, vecs[v].n1y);
      check_pos($sformatf("vec%0d next2", v), n2x, n2y, vecs[v].n2x, vecs[v].n2y);
      check_pos($sformatf("vec%0d curr1", v), c1x, c1y, 16, 13);
    end

    // wrdone in the first DONE cycle commits the old next value.
    do_reset(20, 20);
    cyc(17);
    wrdone = 1'b1;
    cyc(1);
    wrdone = 1'b0;
    check_pos("done_wr curr1", c1x, c1y, 16, 13);
    check_pos("done_wr next1", n1x, n1y, 16, 14);
    check_pos("done_wr curr2", c2x, c2y, 23, 13);

    // Commit then next period: reversal excluded.
    do_reset(20, 20);
    cyc(30);
    check_pos("p0 next1", n1x, n1y, 16, 14);
    check_pos("p0 next2", n2x, n2y, 23, 14);
    pulse_wr();
    check_pos("p1 curr1", c1x, c1y, 16, 14);
    check_pos("p1 curr2", c2x, c2y, 23, 14);
    check_pos("p1 next1", n1x, n1y, 16, 15);
    check_pos("p1 next2", n2x, n2y, 23, 15);

    // enable low: parks in INIT, next holds even though pacman moved, wrdone commits.
    enable = 1'b0;
    px     = 6'd0;
    py     = 5'd0;
    cyc(3 * DELAY);
    check_pos("park next1", n1x, n1y, 16, 15);
    check_pos("park next2", n2x, n2y, 23, 15);
    check_pos("park curr1", c1x, c1y, 16, 14);
    wrdone = 1'b1;
    cyc(1);
    wrdone = 1'b0;
    check_pos("park_wr curr1", c1x, c1y, 16, 15);
    check_pos("park_wr curr2", c2x, c2y, 23, 15);
    enable = 1'b1;
    cyc(30);
    check_pos("reenable next1", n1x, n1y, 15, 15);
    check_pos("reenable next2", n2x, n2y, 22, 15);

    // Asynchronous reset in the middle of the following scan.
    cyc(DELAY + 2 - 30 + 8);
    reset = 1'b0;
    #1;
    check_pos("midscan_rst curr1", c1x, c1y, 16, 13);
    check_pos("midscan_rst next1", n1x, n1y, 16, 13);
    check_pos("midscan_rst curr2", c2x, c2y, 23, 13);
    check_pos("midscan_rst next2", n2x, n2y, 23, 13);
    cyc(2);

    // Chase pacman at (0,0): ghost1 goes up to row 0 then left to (0,0).
    do_reset(0, 0);
    cyc(30);
    for (int k = 0; k < 29; k++) begin
      ex = (k <= 13) ? 16 : 16 - (k - 13);
      ey = (k <= 13) ? 13 - k : 0;
      nx = (k + 1 <= 13) ? 16 : 16 - (k + 1 - 13);
      ny = (k + 1 <= 13) ? 13 - (k + 1) : 0;
      check_pos($sformatf("chase[%0d] curr1", k), c1x, c1y, ex, ey);
      check_pos($sformatf("chase[%0d] next1", k), n1x, n1y, nx, ny);
      check_int($sformatf("chase[%0d] dist", k), int'(c1x) + int'(c1y), 29 - k);
      if (k == 28) begin
        px = 6'd0;
        py = 5'd5;
      end
      pulse_wr();
    end

    // Corner: up and left wrap off-grid, right is the reversal cell.
    check_pos("corner curr1", c1x, c1y, 0, 0);
    check_pos("corner next1", n1x, n1y, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
